// File: rtl/sad_ctrl.sv
// rtl/sad_ctrl.sv - Sequencing controller for the 4-pixel SAD datapath (optional best-candidate tracking: SAD_CTRL_BEST_EN)
module sad_ctrl #(
    parameter int NUM_GROUPS = 8,
    parameter int GROUP_AW   = 3,
    parameter int NUM_CAND   = 16,
    parameter int CAND_AW    = 7,
    parameter int SAD_WIDTH  = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [GROUP_AW-1:0]  ori_addr,
    output logic [CAND_AW-1:0]   can_addr,
    output logic                 dp_rst,
    output logic                 dp_en_in,
    output logic                 dp_en_acum,
    output logic                 dp_en_out,
    input  logic [SAD_WIDTH-1:0] sad_in,
    output logic                 busy,
    output logic                 sad_valid,
    output logic [CAND_AW-1:0]   cand_idx,
    output logic                 done
`ifdef SAD_CTRL_BEST_EN
    ,
    output logic [SAD_WIDTH-1:0] best_sad,
    output logic [CAND_AW-1:0]   best_idx
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 drain_q, drain_d;
    logic [GROUP_AW-1:0]  ori_addr_q, ori_addr_d;
    logic [CAND_AW-1:0]   can_addr_q, can_addr_d;
    logic [CAND_AW-1:0]   cand_q, cand_d;
    logic                 dp_rst_q, dp_rst_d;
    logic                 en_in_q, en_in_d;
    logic                 last1_q, last1_d;
    logic                 en_acum_q, en_acum_d;
    logic                 en_out_q, en_out_d;
    logic                 busy_q, busy_d;
    logic                 sad_valid_q, sad_valid_d;
    logic                 done_q, done_d;
    logic                 last_group;
    logic                 last_cand;
`ifdef SAD_CTRL_BEST_EN
    logic [SAD_WIDTH-1:0] best_sad_q, best_sad_d;
    logic [CAND_AW-1:0]   best_idx_q, best_idx_d;
`else
    logic                 sad_in_unused;
    assign sad_in_unused = ^sad_in;
`endif

    assign last_group = (ori_addr_q == GROUP_AW'(NUM_GROUPS - 1));
    assign last_cand  = (cand_q == CAND_AW'(NUM_CAND - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_q     <= 1'b0;
            ori_addr_q  <= '0;
            can_addr_q  <= '0;
            cand_q      <= '0;
            dp_rst_q    <= 1'b1;
            en_in_q     <= 1'b0;
            last1_q     <= 1'b0;
            en_acum_q   <= 1'b0;
            en_out_q    <= 1'b0;
            busy_q      <= 1'b0;
            sad_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SAD_CTRL_BEST_EN
            best_sad_q  <= '1;
            best_idx_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ori_addr_q  <= ori_addr_d;
            can_addr_q  <= can_addr_d;
            cand_q      <= cand_d;
            dp_rst_q    <= dp_rst_d;
            en_in_q     <= en_in_d;
            last1_q     <= last1_d;
            en_acum_q   <= en_acum_d;
            en_out_q    <= en_out_d;
            busy_q      <= busy_d;
            sad_valid_q <= sad_valid_d;
            done_q      <= done_d;
`ifdef SAD_CTRL_BEST_EN
            best_sad_q  <= best_sad_d;
            best_idx_q  <= best_idx_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        ori_addr_d = ori_addr_q;
        can_addr_d = can_addr_q;
        cand_d     = cand_q;
`ifdef SAD_CTRL_BEST_EN
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    cand_d     = '0;
                    ori_addr_d = '0;
                    can_addr_d = '0;
`ifdef SAD_CTRL_BEST_EN
                    best_sad_d = '1;
                    best_idx_d = '0;
`endif
                end
            end
            S_CLEAR: state_d = S_FETCH;
            S_FETCH: begin
                if (last_group) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    ori_addr_d = ori_addr_q + 1'b1;
                    can_addr_d = can_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_CAPTURE;
                else         drain_d = 1'b1;
            end
            S_CAPTURE: begin
`ifdef SAD_CTRL_BEST_EN
                // Strict compare so that ties keep the earlier candidate.
                if (sad_in < best_sad_q) begin
                    best_sad_d = sad_in;
                    best_idx_d = cand_q;
                end
`endif
                if (last_cand) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_CLEAR;
                    cand_d     = cand_q + 1'b1;
                    ori_addr_d = '0;
                    can_addr_d = can_addr_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        dp_rst_d    = (state_d == S_CLEAR);
        busy_d      = (state_d != S_IDLE);
        sad_valid_d = (state_d == S_CAPTURE);
        done_d      = (state_d == S_DONE);

        // Enables trail the address by one (memory latency) and two (accumulate) cycles.
        en_in_d   = (state_q == S_FETCH);
        last1_d   = (state_q == S_FETCH) && last_group;
        en_acum_d = en_in_q && !last1_q;
        en_out_d  = en_in_q && last1_q;
    end

    assign ori_addr   = ori_addr_q;
    assign can_addr   = can_addr_q;
    assign dp_rst     = dp_rst_q;
    assign dp_en_in   = en_in_q;
    assign dp_en_acum = en_acum_q;
    assign dp_en_out  = en_out_q;
    assign busy       = busy_q;
    assign sad_valid  = sad_valid_q;
    assign cand_idx   = cand_q;
    assign done       = done_q;
`ifdef SAD_CTRL_BEST_EN
    assign best_sad   = best_sad_q;
    assign best_idx   = best_idx_q;
`endif

endmodule

// File: tb/tb_sad_ctrl.sv
// tb/tb_sad_ctrl.sv - Self-checking bench for sad_ctrl with a behavioural datapath and memories
module tb_sad_ctrl;

    localparam int N     = 4;
    localparam int C     = 3;
    localparam int GAW   = 2;
    localparam int CAW   = 4;
    localparam int SW    = 13;
    localparam int PER   = N + 4;
    localparam int TOTAL = C * PER;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [GAW-1:0] ori_addr;
    logic [CAW-1:0] can_addr;
    logic           dp_rst, dp_en_in, dp_en_acum, dp_en_out;
    logic [SW-1:0]  sad_in;
    logic           busy, sad_valid, done;
    logic [CAW-1:0] cand_idx;
`ifdef SAD_CTRL_BEST_EN
    logic [SW-1:0]  best_sad;
    logic [CAW-1:0] best_idx;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] ori_mem [1 << GAW];
    logic [31:0] can_mem [1 << CAW];
    int          exp_tbl [C];
    int          ovr_tbl [1 << CAW];
    bit          ovr_en = 1'b0;

    sad_ctrl #(
        .NUM_GROUPS(N), .GROUP_AW(GAW), .NUM_CAND(C), .CAND_AW(CAW), .SAD_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ori_addr(ori_addr), .can_addr(can_addr),
        .dp_rst(dp_rst), .dp_en_in(dp_en_in), .dp_en_acum(dp_en_acum), .dp_en_out(dp_en_out),
        .sad_in(sad_in), .busy(busy), .sad_valid(sad_valid), .cand_idx(cand_idx),
        .done(done)
`ifdef SAD_CTRL_BEST_EN
        , .best_sad(best_sad), .best_idx(best_idx)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memories and the 4-pixel SAD datapath driven by the DUT.
    function automatic int group_sad(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        for (int p = 0; p < 4; p++) begin
            if (a[8*p +: 8] > b[8*p +: 8]) s += int'(a[8*p +: 8]) - int'(b[8*p +: 8]);
            else                           s += int'(b[8*p +: 8]) - int'(a[8*p +: 8]);
        end
        return s;
    endfunction

    logic [31:0] ori_rd, can_rd;
    logic [SW-1:0] in_r, sum_r, tot_r;

    always @(posedge clk) begin
        ori_rd <= ori_mem[ori_addr];
        can_rd <= can_mem[can_addr];
        if (dp_en_in) in_r <= SW'(group_sad(ori_rd, can_rd));
        if (dp_rst) begin
            sum_r <= '0;
            tot_r <= '0;
        end else begin
            if (dp_en_acum) sum_r <= sum_r + in_r;
            if (dp_en_out)  tot_r <= sum_r + in_r;
        end
    end

    always_comb begin
        sad_in = tot_r;
        if (ovr_en) sad_in = SW'(ovr_tbl[cand_idx]);
    end

    function automatic int ref_sad(input int c);
        int s = 0;
        int a, b;
        for (int g = 0; g < N; g++)
            for (int p = 0; p < 4; p++) begin
                a = int'(ori_mem[g][8*p +: 8]);
                b = int'(can_mem[c*N+g][8*p +: 8]);
                s += (a > b) ? a - b : b - a;
            end
        return s;
    endfunction

    task automatic fill(input int mode);
        logic [7:0] o8;
        for (int i = 0; i < (1 << CAW); i++) can_mem[i] = $urandom;
        for (int g = 0; g < (1 << GAW); g++) ori_mem[g] = $urandom;
        if (mode == 1) begin
            for (int g = 0; g < N; g++)
                for (int p = 0; p < 4; p++) begin
                    o8 = 8'($urandom_range(10, 245));
                    ori_mem[g][8*p +: 8] = o8;
                    for (int c = 0; c < C; c++)
                        can_mem[c*N+g][8*p +: 8] = ($urandom_range(0, 1) == 1) ? o8 + 8'd10 : o8 - 8'd10;
                end
        end
        for (int c = 0; c < C; c++)
            exp_tbl[c] = (mode == 1) ? 160 : (mode == 2) ? ovr_tbl[c] : ref_sad(c);
        ovr_en = (mode == 2);
    endtask

    // One full run: expected per-cycle behaviour from the schedule of N+4 cycles per candidate.
    task automatic run_cands(input bit hold, input bit noise, input int mode);
        int c, o, ga, done_cnt, done_k;
        logic [6:0] got, expv;
        int eb, ei;
        fill(mode);
        eb = (1 << SW) - 1;
        ei = 0;
        for (int i = 0; i < C; i++) if (exp_tbl[i] < eb) begin eb = exp_tbl[i]; ei = i; end
        done_cnt = 0;
        done_k = -1;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= TOTAL + 1; k++) begin
            @(negedge clk);
            if (hold) start = 1'b1;
            else if (noise && k >= 1 && k <= TOTAL) start = ($urandom_range(0, 2) == 0);
            else start = 1'b0;
            c = (k < TOTAL) ? k / PER : C - 1;
            o = (k < TOTAL) ? k % PER : -1;
            expv = {o == 0, (o >= 2 && o <= N + 1), (o >= 3 && o <= N + 1), o == N + 2,
                    k <= TOTAL, o == N + 3, k == TOTAL};
            got = {dp_rst, dp_en_in, dp_en_acum, dp_en_out, busy, sad_valid, done};
            checks++;
            if (got !== expv) begin
                failures++;
                $display("FAIL ctrl k=%0d got=%b exp=%b", k, got, expv);
            end
            checks++;
            if (cand_idx !== CAW'(c)) begin
                failures++;
                $display("FAIL cand_idx k=%0d got=%0d exp=%0d", k, cand_idx, c);
            end
            if (o >= 1 && o <= N + 2) begin
                ga = (o <= N) ? o - 1 : N - 1;
                checks++;
                if (ori_addr !== GAW'(ga) || can_addr !== CAW'(c * N + ga)) begin
                    failures++;
                    $display("FAIL addr k=%0d got=%0d/%0d exp=%0d/%0d", k, ori_addr, can_addr, ga, c * N + ga);
                end
            end
            if (o == N + 3) begin
                checks++;
                if (sad_in !== SW'(exp_tbl[c])) begin
                    failures++;
                    $display("FAIL sad cand=%0d got=%0d exp=%0d", c, sad_in, exp_tbl[c]);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
`ifdef SAD_CTRL_BEST_EN
            if (k == TOTAL) begin
                checks++;
                if (best_sad !== SW'(eb) || best_idx !== CAW'(ei)) begin
                    failures++;
                    $display("FAIL best got=%0d/%0d exp=%0d/%0d", best_sad, best_idx, eb, ei);
                end
            end
`endif
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL done_count got=%0d exp=1", done_cnt);
        end
        checks++;
        if (done_k + 1 != TOTAL + 1) begin
            failures++;
            $display("FAIL done_latency got=%0d exp=%0d", done_k + 1, TOTAL + 1);
        end
        if (!hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || cand_idx !== CAW'(C - 1)) begin
                    failures++;
                    $display("FAIL idle_after busy=%b done=%b cand=%0d exp=0/0/%0d", busy, done, cand_idx, C - 1);
                end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        logic [6:0] got;
        got = {dp_rst, dp_en_in, dp_en_acum, dp_en_out, busy, sad_valid, done};
        checks++;
        if (got !== 7'b1000000 || cand_idx !== '0 || ori_addr !== '0 || can_addr !== '0) begin
            failures++;
            $display("FAIL %s got=%b cand=%0d ori=%0d can=%0d exp=1000000/0/0/0", tag, got, cand_idx, ori_addr, can_addr);
        end
`ifdef SAD_CTRL_BEST_EN
        checks++;
        if (best_sad !== {SW{1'b1}} || best_idx !== '0) begin
            failures++;
            $display("FAIL %s_best got=%0d/%0d exp=%0d/0", tag, best_sad, best_idx, (1 << SW) - 1);
        end
`endif
    endtask

    task automatic test_reset();
        logic [6:0] got;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got = {dp_rst, dp_en_in, dp_en_acum, dp_en_out, busy, sad_valid, done};
            checks++;
            if (got !== 7'b0) begin
                failures++;
                $display("FAIL idle k=%0d got=%b exp=0000000", k, got);
            end
        end
    endtask

    task automatic test_random_runs();
        run_cands(1'b0, 1'b0, 0);
        run_cands(1'b0, 1'b0, 0);
    endtask

    task automatic test_const_diff();
        run_cands(1'b0, 1'b0, 1);
    endtask

    task automatic test_start_while_busy();
        run_cands(1'b0, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        run_cands(1'b1, 1'b0, 0);
        run_cands(1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_abort();
        fill(0);
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= PER + 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (busy !== 1'b1 || cand_idx !== CAW'(1)) begin
            failures++;
            $display("FAIL abort_pre busy=%b cand=%0d exp=1/1", busy, cand_idx);
        end
        #2 rst = 1'b1;
        #1 check_reset_values("abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_reset_values("abort_hold");
        end
        rst = 1'b0;
        @(negedge clk);
        run_cands(1'b0, 1'b0, 0);
    endtask

`ifdef SAD_CTRL_BEST_EN
    task automatic test_best();
        ovr_tbl[0] = 500;
        ovr_tbl[1] = 120;
        ovr_tbl[2] = 120;
        run_cands(1'b0, 1'b0, 2);
        ovr_en = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << CAW); i++) ovr_tbl[i] = 0;
        test_reset();
        test_random_runs();
        test_const_diff();
        test_start_while_busy();
        test_back_to_back();
        test_reset_abort();
`ifdef SAD_CTRL_BEST_EN
        test_best();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_ctrl.md
Name: sad_ctrl

Overview:
- Sequencing controller that drives the 4-pixel SAD datapath: the initiator side of its en_in/en_acum/en_out/rst control interface.
- On start, for each candidate block in turn:
  - generates original/candidate memory read addresses;
  - pulses the datapath clear and enables with correct pipeline alignment;
  - reports each candidate's final SAD.
- Sits between the motion-estimation top level and the SAD datapath plus its two synchronous-read pixel memories.

Parameters:
- NUM_GROUPS, 8: 4-pixel groups per block (8 -> 32-pixel block; max SAD 8160 fits 13 bits).
- GROUP_AW, 3: width of ori_addr; 2**GROUP_AW >= NUM_GROUPS.
- NUM_CAND, 16: candidate blocks evaluated per start.
- CAND_AW, 7: width of can_addr; 2**CAND_AW >= NUM_GROUPS*NUM_CAND.
- SAD_WIDTH, 13: width of the datapath SAD result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin evaluation; sampled only in IDLE.
- ori_addr  out  GROUP_AW  original-block memory address (1-cycle read latency).
- can_addr  out  CAND_AW  candidate memory address = cand_idx*NUM_GROUPS + group.
- dp_rst  out  1  synchronous clear to datapath.
- dp_en_in  out  1  datapath input-register enable.
- dp_en_acum  out  1  datapath accumulate enable.
- dp_en_out  out  1  datapath total-register enable.
- sad_in  in  SAD_WIDTH  datapath out_sad.
- busy  out  1  high from the cycle after start is accepted until DONE inclusive.
- sad_valid  out  1  one-cycle pulse: sad_in is the final SAD of cand_idx.
- cand_idx  out  CAND_AW  index of the candidate in progress.
- done  out  1  one-cycle pulse after the last candidate.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, dp_rst=1, every other output 0.
- Reset mid-operation aborts immediately; no done pulse is issued.
- States: IDLE, CLEAR, FETCH, DRAIN, CAPTURE, DONE.
- IDLE: dp_rst=0. start=1 -> CLEAR, cand_idx=0. start while busy is ignored.
- CLEAR (1 cycle): dp_rst=1 clears datapath sum/total registers -> FETCH with group=0.
- FETCH (NUM_GROUPS cycles): ori_addr=group, can_addr=cand_idx*NUM_GROUPS+group, group++. After the last group -> DRAIN.
- Enable alignment, with F0 = first FETCH cycle:
  - dp_en_in high in cycles F0+1 .. F0+NUM_GROUPS (data arrives 1 cycle after address);
  - dp_en_acum high in cycles F0+2 .. F0+NUM_GROUPS (groups 0..N-2);
  - dp_en_out high in cycle F0+NUM_GROUPS+1 only (last group: total = sum + last group);
  - implement as a 2-stage shift of fetch-valid and last-group flags;
  - enables are never asserted outside these windows.
- DRAIN (2 cycles): no new addresses; address outputs hold their last value.
- CAPTURE (1 cycle, = F0+NUM_GROUPS+2): sad_valid=1; sad_in holds this candidate's SAD.
  - If cand_idx == NUM_CAND-1 -> DONE.
  - Else cand_idx++ -> CLEAR.
- DONE (1 cycle): done=1 -> IDLE. cand_idx holds its last value until the next start.
- Per-candidate cost: NUM_GROUPS+4 cycles. Total from the start-accept edge to done: NUM_CAND*(NUM_GROUPS+4)+1 cycles.
- start held high continuously: a new run begins on the cycle after DONE.
- Arithmetic: no arithmetic on SAD values except the optional compare. Address math wraps only if the parameters are misconfigured; this is not checked.

Optional Feature:
- Macro: SAD_CTRL_BEST_EN.
- When defined, add outputs best_sad (SAD_WIDTH) and best_idx (CAND_AW):
  - both are set to all-ones and 0 on start accept;
  - in CAPTURE, if sad_in < best_sad (strict), load sad_in and cand_idx;
  - ties keep the lower index;
  - values are stable and valid when done pulses and are held until the next start;
  - reset values: best_sad all-ones, best_idx 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> dp_rst=1 during rst; after release, all enables 0, busy=0 indefinitely with start=0.
- NUM_GROUPS=4, NUM_CAND=3, start pulse -> per candidate: dp_rst 1 cycle, ori_addr 0..3, can_addr 4c..4c+3, en_in 4 cycles, en_acum 3, en_out 1; done exactly 25 cycles after the accept edge.
- Datapath model with constant |diff|=10 per pixel -> sad_valid sees sad_in=160 for every candidate (N=4).
- start pulsed again while busy -> ignored; run completes at the same cycle count with a single done.
- rst asserted during FETCH of candidate 1 -> outputs are immediately at reset values; a subsequent start restarts at cand_idx=0.
- SAD_CTRL_BEST_EN, candidate SADs 500, 120, 120 -> best_sad=120, best_idx=1 at done.
